// File: rtl/issue_stage_pkg.sv
// -----------------------------------------------------------------------------
// issue_stage_pkg
//
// Purpose: shared definitions for the in-order issue stage. This file holds the
// default register-file geometry, the issue-stage state encoding and the record
// types for a decoded instruction and for an issued instruction.
//
// Contents:
//   ISS_XWDT    - default register-index width
//   ISS_XN      - default register count (2**ISS_XWDT)
//   ISS_OPW     - default opaque decoded-op payload width
//   iss_state_e - ST_INIT (scoreboard clear sweep) / ST_RUN (issuing)
//   iss_instr_t - decoded instruction held in the hold register
//   iss_out_t   - issued instruction held in the output register
//
// The record types use the package defaults. The top level's parameters
// default to these values and are expected to match them.
// -----------------------------------------------------------------------------
package issue_stage_pkg;

    localparam int ISS_XWDT = 6;
    localparam int ISS_XN   = 1 << ISS_XWDT;
    localparam int ISS_OPW  = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } iss_state_e;

    // Decoded instruction waiting for its hazard check.
    typedef struct packed {
        logic [ISS_XWDT-1:0] rd;
        logic [ISS_XWDT-1:0] rs1;
        logic [ISS_XWDT-1:0] rs2;
        logic                use_rs1;
        logic                use_rs2;
        logic [ISS_OPW-1:0]  op;
    } iss_instr_t;

    // Issued instruction presented to execute. The use flags only steer the
    // hazard check, so they are not carried forward.
    typedef struct packed {
        logic [ISS_XWDT-1:0] rd;
        logic [ISS_XWDT-1:0] rs1;
        logic [ISS_XWDT-1:0] rs2;
        logic [ISS_OPW-1:0]  op;
    } iss_out_t;

endpackage

// File: rtl/issue_hazard.sv
// -----------------------------------------------------------------------------
// issue_hazard
//
// Purpose: combinational hazard check for the instruction in the hold register.
// The instruction must wait if any register it reads, or the register it
// writes, has a pending write in the scoreboard. Register 0 is hard-wired and
// never causes a hazard.
//
// Ports:
//   i_valid    - hold register contains an instruction
//   i_rd       - destination register index
//   i_rs1      - first source register index
//   i_rs2      - second source register index
//   i_use_rs1  - first source is actually read
//   i_use_rs2  - second source is actually read
//   i_rlocks   - scoreboard lock vector, bit i = register i pending write
//   o_hazard   - instruction must not issue this cycle
// -----------------------------------------------------------------------------
module issue_hazard
    import issue_stage_pkg::*;
#(
    parameter int XWDT = ISS_XWDT,
    parameter int XN   = ISS_XN
) (
    input  logic            i_valid,
    input  logic [XWDT-1:0] i_rd,
    input  logic [XWDT-1:0] i_rs1,
    input  logic [XWDT-1:0] i_rs2,
    input  logic            i_use_rs1,
    input  logic            i_use_rs2,
    input  logic [XN-1:0]   i_rlocks,
    output logic            o_hazard
);

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_rd_hit;

    assign w_rs1_hit = i_use_rs1 && (i_rs1 != '0) && i_rlocks[i_rs1];
    assign w_rs2_hit = i_use_rs2 && (i_rs2 != '0) && i_rlocks[i_rs2];
    // A pending write to our own destination is a WAW hazard: issuing now
    // would let the older write land after ours.
    assign w_rd_hit  = (i_rd != '0) && i_rlocks[i_rd];

    assign o_hazard  = i_valid && (w_rs1_hit || w_rs2_hit || w_rd_hit);

endmodule

// File: rtl/issue_stage.sv
// -----------------------------------------------------------------------------
// issue_stage
//
// Purpose: in-order issue stage between decode and execute. After reset it
// sweeps the external scoreboard clear port over registers 1..XN-1, then
// accepts one decoded instruction at a time into a hold register H. When H is
// free of scoreboard hazards and the output register O can take it, the
// instruction moves into O and its destination is locked in the scoreboard
// through rset in the same cycle. The scoreboard state itself lives outside.
//
// Parameters:
//   XWDT - register-index width
//   XN   - register count (2**XWDT)
//   OPW  - opaque decoded-op payload width
//
// Ports:
//   clk        - sole clock, all state updates on its rising edge
//   rst        - synchronous active-high reset
//   in_valid   - decoder presents an instruction
//   in_ready   - stage accepts the instruction this cycle
//   in_rd      - destination register index
//   in_rs1     - first source register index
//   in_rs2     - second source register index
//   in_use_rs1 - first source is read
//   in_use_rs2 - second source is read
//   in_op      - payload, carried unmodified
//   out_valid  - issued instruction presented to execute
//   out_ready  - execute accepts
//   out_rd     - issued destination index
//   out_rs1    - issued first source index
//   out_rs2    - issued second source index
//   out_op     - issued payload
//   rlocks     - scoreboard lock vector, bit i = register i pending write
//   rset       - register to lock this cycle, 0 = no lock request
//   rinit      - scoreboard clear index during the init sweep, 0 = idle
//   busy       - high while the init sweep runs (and while rst is asserted)
// -----------------------------------------------------------------------------
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int XWDT = ISS_XWDT,
    parameter int XN   = ISS_XN,
    parameter int OPW  = ISS_OPW
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XWDT-1:0] in_rd,
    input  logic [XWDT-1:0] in_rs1,
    input  logic [XWDT-1:0] in_rs2,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic [OPW-1:0]  in_op,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XWDT-1:0] out_rd,
    output logic [XWDT-1:0] out_rs1,
    output logic [XWDT-1:0] out_rs2,
    output logic [OPW-1:0]  out_op,

    input  logic [XN-1:0]   rlocks,
    output logic [XWDT-1:0] rset,
    output logic [XWDT-1:0] rinit,
    output logic            busy
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    iss_state_e      r_state;
    iss_state_e      w_state_nxt;
    logic [XWDT-1:0] r_sweep;
    logic [XWDT-1:0] w_sweep_nxt;
    logic            w_sweep_last;

    logic            r_h_valid;
    iss_instr_t      r_h;
    logic            r_o_valid;
    iss_out_t        r_o;

    iss_instr_t      w_in_instr;
    logic            w_run;
    logic            w_hazard;
    logic            w_issue;
    logic            w_accept;

    // -------------------------------------------------------------------------
    // Handshake and issue decision
    // -------------------------------------------------------------------------
    // Qualifying with !rst keeps every request output quiet while reset is
    // held, even though the registers only clear at the next edge.
    assign w_run    = (r_state == ST_RUN) && !rst;

    issue_hazard #(
        .XWDT (XWDT),
        .XN   (XN)
    ) u_hazard (
        .i_valid   (r_h_valid),
        .i_rd      (r_h.rd),
        .i_rs1     (r_h.rs1),
        .i_rs2     (r_h.rs2),
        .i_use_rs1 (r_h.use_rs1),
        .i_use_rs2 (r_h.use_rs2),
        .i_rlocks  (rlocks),
        .o_hazard  (w_hazard)
    );

    assign w_issue  = w_run && r_h_valid && !w_hazard && (!r_o_valid || out_ready);
    // H can refill in the same cycle it empties, which gives one instruction
    // per cycle when nothing stalls.
    assign in_ready = w_run && (!r_h_valid || w_issue);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_in_instr.rd      = in_rd;
        w_in_instr.rs1     = in_rs1;
        w_in_instr.rs2     = in_rs2;
        w_in_instr.use_rs1 = in_use_rs1;
        w_in_instr.use_rs2 = in_use_rs2;
        w_in_instr.op      = in_op;
    end

    // -------------------------------------------------------------------------
    // INIT/RUN sequencing
    // -------------------------------------------------------------------------
    assign w_sweep_last = (r_sweep == XWDT'(XN - 1));

    // NOTE: every signal written here gets a value before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        case (r_state)
            ST_INIT: begin
                if (w_sweep_last) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_sweep_nxt = r_sweep + 1'b1;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so that
    // every register samples values from before the edge, independent of the
    // order of statements.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_sweep   <= XWDT'(1);
            r_h_valid <= 1'b0;
            r_o_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;

            if (w_accept) begin
                r_h_valid <= 1'b1;
            end else if (w_issue) begin
                r_h_valid <= 1'b0;
            end

            if (w_issue) begin
                r_o_valid <= 1'b1;
            end else if (out_ready) begin
                r_o_valid <= 1'b0;
            end
        end
    end

    // NOTE: the payload registers carry no reset; they are only observed while
    // their valid bit is set, and the valid bits are what reset clears.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_h <= w_in_instr;
        end
        if (w_issue) begin
            r_o.rd  <= r_h.rd;
            r_o.rs1 <= r_h.rs1;
            r_o.rs2 <= r_h.rs2;
            r_o.op  <= r_h.op;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Register 0 as destination yields rset=0, which is already "no lock".
    assign rset      = w_issue ? r_h.rd : '0;
    assign rinit     = ((r_state == ST_INIT) && !rst) ? r_sweep : '0;
    assign busy      = (r_state == ST_INIT) || rst;

    assign out_valid = r_o_valid && !rst;
    assign out_rd    = rst ? '0 : r_o.rd;
    assign out_rs1   = rst ? '0 : r_o.rs1;
    assign out_rs2   = rst ? '0 : r_o.rs2;
    assign out_op    = rst ? '0 : r_o.op;

endmodule

// File: tb/tb_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_issue_stage
//
// Self-checking bench for issue_stage: init sweep, a table of single
// instruction hazard cases, hand-written multi-cycle sequences, and a random
// run checked against an in-order queue model of the issue rules.
// -----------------------------------------------------------------------------
module tb_issue_stage;

    localparam int XWDT = 6;
    localparam int XN   = 64;
    localparam int OPW  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XWDT-1:0] in_rd;
    logic [XWDT-1:0] in_rs1;
    logic [XWDT-1:0] in_rs2;
    logic            in_use_rs1;
    logic            in_use_rs2;
    logic [OPW-1:0]  in_op;
    logic            out_valid;
    logic            out_ready;
    logic [XWDT-1:0] out_rd;
    logic [XWDT-1:0] out_rs1;
    logic [XWDT-1:0] out_rs2;
    logic [OPW-1:0]  out_op;
    logic [XN-1:0]   rlocks;
    logic [XWDT-1:0] rset;
    logic [XWDT-1:0] rinit;
    logic            busy;

    int n_total = 0;
    int n_bad   = 0;

    issue_stage #(
        .XWDT (XWDT),
        .XN   (XN),
        .OPW  (OPW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_use_rs1 (in_use_rs1),
        .in_use_rs2 (in_use_rs2),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_op     (out_op),
        .rlocks     (rlocks),
        .rset       (rset),
        .rinit      (rinit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want summary");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on
    // the falling edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_ins(input logic v, input logic [XWDT-1:0] rd, input logic [XWDT-1:0] rs1,
                             input logic [XWDT-1:0] rs2, input logic u1, input logic u2,
                             input logic [OPW-1:0] op);
        in_valid   = v;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_rs1 = u1;
        in_use_rs2 = u2;
        in_op      = op;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            adv();
        end
    endtask

    task automatic wait_init();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            settle();
            if (!busy) done = 1'b1;
            else adv();
        end
        check("init completes", done, 1'b1);
        adv();
    endtask

    // -------------------------------------------------------------------------
    // Reference model for the random run
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [XWDT-1:0] rd;
        logic [XWDT-1:0] rs1;
        logic [XWDT-1:0] rs2;
        logic            u1;
        logic            u2;
        logic [OPW-1:0]  op;
    } tb_ins_t;

    function automatic logic blocked(input tb_ins_t x, input logic [XN-1:0] l);
        return (x.u1 && x.rs1 != 0 && l[x.rs1]) ||
               (x.u2 && x.rs2 != 0 && l[x.rs2]) ||
               (x.rd != 0 && l[x.rd]);
    endfunction

    typedef struct {
        logic [XWDT-1:0] rd;
        logic [XWDT-1:0] rs1;
        logic [XWDT-1:0] rs2;
        logic            u1;
        logic            u2;
        logic [XN-1:0]   locks;
        logic [XWDT-1:0] exp_rset;
        logic            exp_issue;
    } vec_t;

    vec_t        vecs[8];
    tb_ins_t     pend_q[$];
    tb_ins_t     iss_q[$];
    tb_ins_t     cur;
    tb_ins_t     popped;
    logic [XN-1:0] locks_m;
    logic        drain;
    logic        o_full;
    logic        exp_issue;
    logic        exp_in_ready;
    int          n_rset5;

    initial begin
        vecs[0] = '{6'd5,  6'd3,  6'd0,  1'b1, 1'b0, 64'd0,            6'd5,  1'b1};
        vecs[1] = '{6'd5,  6'd3,  6'd0,  1'b1, 1'b0, (64'd1 << 3),     6'd0,  1'b0};
        vecs[2] = '{6'd5,  6'd3,  6'd0,  1'b0, 1'b0, (64'd1 << 3),     6'd5,  1'b1};
        vecs[3] = '{6'd5,  6'd0,  6'd7,  1'b0, 1'b1, (64'd1 << 7),     6'd0,  1'b0};
        vecs[4] = '{6'd5,  6'd1,  6'd2,  1'b1, 1'b1, (64'd1 << 5),     6'd0,  1'b0};
        vecs[5] = '{6'd0,  6'd0,  6'd0,  1'b1, 1'b1, {64{1'b1}},       6'd0,  1'b1};
        vecs[6] = '{6'd0,  6'd9,  6'd0,  1'b1, 1'b0, {64{1'b1}},       6'd0,  1'b0};
        vecs[7] = '{6'd63, 6'd62, 6'd61, 1'b1, 1'b1, 64'd1,            6'd63, 1'b1};

        rst       = 1'b1;
        out_ready = 1'b1;
        rlocks    = '0;
        drive_ins(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);

        // ---------------- reset + init sweep ----------------
        adv();
        settle();
        check("rst busy", busy, 1'b1);
        check("rst rinit", rinit, 0);
        check("rst in_ready", in_ready, 1'b0);
        check("rst out_valid", out_valid, 1'b0);
        check("rst rset", rset, 0);
        adv();
        rst = 1'b0;
        for (int i = 1; i < XN; i++) begin
            settle();
            check($sformatf("sweep rinit %0d", i), rinit, 64'(i));
            check($sformatf("sweep busy %0d", i), busy, 1'b1);
            adv();
        end
        settle();
        check("run busy", busy, 1'b0);
        check("run in_ready", in_ready, 1'b1);
        check("run rinit", rinit, 0);
        adv();

        // ---------------- table: single-instruction hazard cases ----------------
        for (int k = 0; k < 8; k++) begin
            rlocks    = vecs[k].locks;
            out_ready = 1'b1;
            drive_ins(1'b1, vecs[k].rd, vecs[k].rs1, vecs[k].rs2, vecs[k].u1, vecs[k].u2, OPW'(32'h100 + k));
            settle();
            check($sformatf("tbl%0d accept", k), in_ready, 1'b1);
            adv();
            in_valid = 1'b0;
            settle();
            check($sformatf("tbl%0d rset", k), rset, vecs[k].exp_rset);
            adv();
            settle();
            check($sformatf("tbl%0d issued", k), out_valid, vecs[k].exp_issue);
            adv();
            rlocks = '0;
            idle(4);
        end

        // ---------------- dependent pair A(rd=5) -> B(rs1=5) ----------------
        locks_m = '0;
        n_rset5 = 0;
        drive_ins(1'b1, 6'd5, 6'd0, 6'd0, 1'b0, 1'b0, 32'hA5);
        settle();
        check("dep A accept", in_ready, 1'b1);
        adv();
        drive_ins(1'b1, 6'd6, 6'd5, 6'd0, 1'b1, 1'b0, 32'hB6);
        settle();
        check("dep A rset", rset, 6'd5);
        check("dep B accept", in_ready, 1'b1);
        if (rset == 6'd5) n_rset5++;
        if (rset != 0) locks_m[rset] = 1'b1;
        adv();
        in_valid = 1'b0;
        rlocks   = locks_m;
        settle();
        check("dep A out_valid", out_valid, 1'b1);
        check("dep A out_rd", out_rd, 6'd5);
        check("dep B held", rset, 0);
        if (rset == 6'd5) n_rset5++;
        adv();
        for (int i = 0; i < 2; i++) begin
            settle();
            check("dep B still held", rset, 0);
            check("dep no out", out_valid, 1'b0);
            if (rset == 6'd5) n_rset5++;
            adv();
        end
        check("dep rset5 once", 64'(n_rset5), 1);
        locks_m[5] = 1'b0;
        rlocks     = locks_m;
        settle();
        check("dep B issues after clear", rset, 6'd6);
        adv();
        settle();
        check("dep B out_valid", out_valid, 1'b1);
        check("dep B out_rd", out_rd, 6'd6);
        check("dep B out_rs1", out_rs1, 6'd5);
        check("dep B out_op", out_op, 32'hB6);
        adv();
        rlocks = '0;
        idle(3);

        // ---------------- independent stream rd=1..8 ----------------
        for (int c = 0; c < 11; c++) begin
            if (c < 8) drive_ins(1'b1, XWDT'(c + 1), 6'd0, 6'd0, 1'b0, 1'b0, OPW'(32'h200 + c));
            else in_valid = 1'b0;
            settle();
            if (c < 8) check($sformatf("stream accept %0d", c), in_ready, 1'b1);
            check($sformatf("stream rset c%0d", c), rset, (c >= 1 && c <= 8) ? 64'(c) : 64'd0);
            check($sformatf("stream out_valid c%0d", c), out_valid, (c >= 2 && c <= 9));
            if (c >= 2 && c <= 9) check($sformatf("stream out_rd c%0d", c), out_rd, 64'(c - 1));
            adv();
        end
        idle(2);

        // ---------------- output stall with two pending ----------------
        out_ready = 1'b0;
        drive_ins(1'b1, 6'd10, 6'd0, 6'd0, 1'b0, 1'b0, 32'hAA);
        settle();
        check("stall A accept", in_ready, 1'b1);
        adv();
        drive_ins(1'b1, 6'd11, 6'd0, 6'd0, 1'b0, 1'b0, 32'hBB);
        settle();
        check("stall A rset", rset, 6'd10);
        check("stall B accept", in_ready, 1'b1);
        adv();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("stall out_valid", out_valid, 1'b1);
            check("stall out_rd", out_rd, 6'd10);
            check("stall out_op", out_op, 32'hAA);
            check("stall in_ready", in_ready, 1'b0);
            check("stall rset", rset, 0);
            adv();
        end
        out_ready = 1'b1;
        settle();
        check("drain A out_rd", out_rd, 6'd10);
        check("drain B rset", rset, 6'd11);
        adv();
        settle();
        check("drain B out_valid", out_valid, 1'b1);
        check("drain B out_rd", out_rd, 6'd11);
        check("drain B out_op", out_op, 32'hBB);
        adv();
        settle();
        check("drain empty", out_valid, 1'b0);
        adv();

        // ---------------- random run against queue model ----------------
        locks_m = '0;
        for (int c = 0; c < 1500; c++) begin
            drain      = (c >= 1460);
            cur.rd     = XWDT'($urandom_range(1, 8));
            cur.rs1    = XWDT'($urandom_range(0, 8));
            cur.rs2    = XWDT'($urandom_range(0, 8));
            cur.u1     = 1'($urandom_range(0, 1));
            cur.u2     = 1'($urandom_range(0, 1));
            cur.op     = OPW'($urandom);
            drive_ins(!drain && ($urandom_range(0, 2) != 0), cur.rd, cur.rs1, cur.rs2, cur.u1, cur.u2, cur.op);
            out_ready  = drain || ($urandom_range(0, 3) != 0);
            rlocks     = locks_m;
            rlocks[0]  = 1'($urandom_range(0, 1));
            settle();

            o_full       = (iss_q.size() != 0);
            exp_issue    = (pend_q.size() != 0) && !blocked(pend_q[0], rlocks) && (!o_full || out_ready);
            exp_in_ready = (pend_q.size() == 0) || exp_issue;
            check("rnd rset", rset, exp_issue ? pend_q[0].rd : 6'd0);
            check("rnd in_ready", in_ready, exp_in_ready);
            check("rnd out_valid", out_valid, o_full);
            if (o_full) begin
                check("rnd out_rd", out_rd, iss_q[0].rd);
                check("rnd out_rs1", out_rs1, iss_q[0].rs1);
                check("rnd out_rs2", out_rs2, iss_q[0].rs2);
                check("rnd out_op", out_op, iss_q[0].op);
            end

            if (o_full && out_ready) popped = iss_q.pop_front();
            for (int b = 1; b < XN; b++) begin
                if (locks_m[b] && (drain || $urandom_range(0, 3) == 0)) locks_m[b] = 1'b0;
            end
            if (exp_issue) begin
                popped = pend_q.pop_front();
                iss_q.push_back(popped);
                locks_m[popped.rd] = 1'b1;
            end
            if (in_valid && exp_in_ready) pend_q.push_back(cur);
            adv();
        end
        check("rnd pend drained", 64'(pend_q.size()), 0);
        check("rnd out drained", 64'(iss_q.size()), 0);
        rlocks = '0;
        idle(2);

        // ---------------- reset while B stalled on a lock ----------------
        drive_ins(1'b1, 6'd5, 6'd0, 6'd0, 1'b0, 1'b0, 32'hC5);
        adv();
        drive_ins(1'b1, 6'd6, 6'd5, 6'd0, 1'b1, 1'b0, 32'hC6);
        adv();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rlocks    = 64'd1 << 5;
        adv();
        settle();
        check("pre-rst B stalled", rset, 0);
        adv();
        rst = 1'b1;
        settle();
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst rset", rset, 0);
        check("midrst busy", busy, 1'b1);
        check("midrst rinit", rinit, 0);
        check("midrst in_ready", in_ready, 1'b0);
        check("midrst out_rd", out_rd, 0);
        adv();
        rst       = 1'b0;
        rlocks    = '0;
        out_ready = 1'b1;
        settle();
        check("restart rinit 1", rinit, 6'd1);
        check("restart busy", busy, 1'b1);
        check("restart out_valid", out_valid, 1'b0);
        adv();
        settle();
        check("restart rinit 2", rinit, 6'd2);
        adv();
        wait_init();
        for (int i = 0; i < 4; i++) begin
            settle();
            check("discarded no rset", rset, 0);
            check("discarded no out", out_valid, 1'b0);
            adv();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_stage.md
ISSUE_STAGE -- requirements
Module: issue_stage

Interface
REQ-001 Parameter XWDT, default 6, register-index width.
REQ-002 Parameter XN, default 64, register count (2**XWDT).
REQ-003 Parameter OPW, default 32, opaque decoded-op payload width.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  decoder presents an instruction.
REQ-007 in_ready  output  1  stage accepts the instruction this cycle.
REQ-008 in_rd, in_rs1, in_rs2  input  XWDT each  destination/source indices.
REQ-009 in_use_rs1, in_use_rs2  input  1 each  source operand is read.
REQ-010 in_op  input  OPW  payload, carried unmodified.
REQ-011 out_valid  output  1  issued instruction presented to execute.
REQ-012 out_ready  input  1  execute accepts.
REQ-013 out_rd, out_rs1, out_rs2  output  XWDT each; out_op  output  OPW.
REQ-014 rlocks  input  XN  scoreboard lock vector, bit i = register i pending write.
REQ-015 rset  output  XWDT  register to lock; 0 = no lock request.
REQ-016 rinit  output  XWDT  scoreboard clear index during init sweep; 0 = idle.
REQ-017 busy  output  1  high while in INIT state.

Function
REQ-018 Two states: INIT, RUN; reset enters INIT.
REQ-019 INIT: rinit counts 1,2,...,XN-1 on successive cycles; after the cycle with rinit=XN-1, next state RUN; rinit=0 in RUN.
REQ-020 INIT: in_ready=0, out_valid=0, rset=0, busy=1.
REQ-021 Hold register H (valid + fields) and output register O (valid + fields).
REQ-022 Accept (in_valid && in_ready) at edge loads H; in_ready = RUN && (!H.valid || issue).
REQ-023 hazard = H.valid && ((use_rs1 && rs1!=0 && rlocks[rs1]) || (use_rs2 && rs2!=0 && rlocks[rs2]) || (rd!=0 && rlocks[rd])).
REQ-024 issue = RUN && H.valid && !hazard && (!O.valid || out_ready); issue moves H into O at the edge.
REQ-025 rset = H.rd during an issue cycle, else 0 (combinational, same cycle as issue).
REQ-026 O holds stable while out_valid && !out_ready; O clears on out_ready with no issue.
REQ-027 Latency: instruction accepted at edge N presents out_valid from cycle N+2 when hazard-free and unstalled.
REQ-028 Throughput: one instruction per cycle with no hazards and out_ready held high.
REQ-029 Dependent back-to-back pair: the younger instruction shall observe the older lock (visible one cycle after rset) and stall; no bypass window.
REQ-030 Lock cleared by writeback in cycle N is honoured from cycle N+1; one extra stall cycle is accepted.
REQ-031 Register 0 never causes a hazard and never generates rset.
REQ-032 In-order: a hazarded H blocks all younger instructions.

Reset
REQ-033 rst at any cycle, including mid-stall or mid-INIT: H.valid=0, O.valid=0, state INIT, sweep counter=1 on the next cycle.
REQ-034 During rst-asserted cycles all outputs shall be 0 except busy=1.
REQ-035 Instructions in H or O at reset are discarded; no rset is produced for them.

Structure
REQ-036 Shared package holds XWDT/XN defaults, issue-state enum (INIT, RUN), and the decoded-instruction struct (rd, rs1, rs2, use flags, op).
REQ-037 One sub-module, issue_hazard: combinational hazard check over H fields and rlocks.
REQ-038 The top level muxes rinit/rset into the scoreboard clear/set ports; this block owns neither scoreboard state.

Verification
REQ-039 Reset then idle -> busy=1 for 63 cycles, rinit 1..63 in order, then busy=0, in_ready=1.
REQ-040 A: rd=5; B: rs1=5 back-to-back, out_ready=1, model scoreboard -> A out at cycle+2, rset=5 once, B held until bit 5 cleared, B issues the cycle after clear.
REQ-041 Independent stream rd=1..8, rs=0 -> eight consecutive out_valid cycles, rset=1..8 in order.
REQ-042 out_ready=0 for 4 cycles with two instructions pending -> O stable, in_ready=0, no rset, then drains in order.
REQ-043 rd=0, rs1=0 with rlocks all ones -> issues without stall, rset=0.
REQ-044 rst asserted while B stalled on lock -> out_valid=0, rset=0, INIT sweep restarts at rinit=1.
